blinds_func_learner: RTL and testbench
======================================

Name: blinds_func_learner

Overview:
- Sequential "reverse" companion to the blinds logic (out = func[{a,b}]).
- Drives a/b through all four combinations into an external blinds unit, samples its out after a settle interval, and reconstructs the 4-bit func truth table.
- Used as an on-chip self-identifier/self-check for the roller-blind control logic, with a start/busy/done handshake towards a supervisor.

Parameters:
- SETTLE, 1, cycles each {a,b} combination is held before out is sampled; legal range 1..255.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a learning run; sampled only in IDLE
- a  output  1  drive to blinds unit input a (MSB of index)
- b  output  1  drive to blinds unit input b (LSB of index)
- sample_in  input  1  blinds unit out, fed back
- busy  output  1  high while a run is in progress (DRIVE state)
- done  output  1  one-cycle pulse when func_out has been updated
- func_out  output  4  learned truth table; bit i = out observed for {a,b}=i
- expected_func  input  4  reference table (present only with BLINDS_CHECK_EN)
- mismatch  output  1  result flag (present only with BLINDS_CHECK_EN)

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a=0, b=0, busy=0, done=0, func_out=4'h0, internal capture register=0, settle counter=0, mismatch=0.
- State register: IDLE, DRIVE, DONE. Index register idx[1:0] drives {a,b} directly; 8-bit settle counter cnt.
- IDLE: {a,b}=00. If start=1 at an edge, go to DRIVE with idx=0, cnt=0, capture=0, busy=1.
- DRIVE: cnt increments each edge. At the edge where cnt==SETTLE-1:
  - capture[idx] <= sample_in.
  - If idx!=3: idx+1 and cnt=0.
  - If idx==3: go to DONE; func_out <= capture with bit 3 = sample_in; busy=0.
- Each combination is held for exactly SETTLE cycles. sample_in is sampled in the last cycle of each hold.
- DONE: done=1 for exactly one cycle, {a,b}=00, then unconditional return to IDLE. start is ignored in DONE.
- Latency: done is high in the cycle following the 4*SETTLE-th rising edge after the edge that accepted start. func_out is valid from that same cycle.
- func_out holds its last value until the next run completes. It is not cleared at the start of a run.
- start while busy or during DONE: ignored, with no queuing. A start held continuously causes back-to-back runs separated by one DONE cycle and one IDLE cycle.
- Reset asserted mid-run: the run is aborted immediately and the partial capture is discarded. func_out returns to 0, not to the previous result.
- sample_in is treated as synchronous to clk. Metastability handling is the integrator's responsibility.

Optional Feature:
- Macro: BLINDS_CHECK_EN.
- Defined:
  - expected_func and mismatch ports exist.
  - At the edge that enters DONE, mismatch <= (learned func != expected_func).
  - mismatch holds until the next run completes; it resets to 0.
- Undefined:
  - Neither port exists and no compare logic is synthesised.
  - All other behaviour is identical.

Test Plan:
1. SETTLE=1; model blinds with func=4'hA; pulse start -> {a,b} steps 00,01,10,11 on consecutive cycles; done pulses once 4 edges after start; func_out=4'hA; busy high for exactly 4 cycles.
2. SETTLE=3; func=4'h6 -> each {a,b} value held 3 cycles; done one cycle after the 12th edge following start; func_out=4'h6.
3. Run with func=4'hA, then start pulsed mid-run -> pulse ignored; func_out=4'hA, single done; then change func to 4'h5 and start again -> func_out stays 4'hA until the second done, then becomes 4'h5.
4. Assert rst_n low during the 2nd combination of a run with func=4'hF -> a=b=busy=done=0 and func_out=0 immediately (asynchronously); after release, state is IDLE and there is no done until a new start.
5. start held high for 12 cycles, SETTLE=1 -> done pulses 6 cycles apart; func_out is correct each time; {a,b}=00 during the DONE and IDLE cycles.
6. With BLINDS_CHECK_EN: expected_func=4'hA, blinds func=4'hA -> mismatch=0; then blinds func=4'hB -> mismatch=1 at done and held until the next completion.

Source files
------------

// File: rtl/blinds_func_learner.sv
// blinds_func_learner
//   Learns the 4-bit truth table of an external blinds unit (out = func[{a,b}]).
//   It drives {a,b} through 00,01,10,11 and holds each value for SETTLE cycles.
//   sample_in is sampled in the last cycle of each hold, and the result is
//   published on func_out together with a one-cycle done pulse.
//
// Parameters:
//   SETTLE        cycles each {a,b} combination is held (1..255)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start         request a learning run (accepted only in IDLE)
//   a, b          drive to the blinds unit, {a,b} = current table index
//   sample_in     blinds unit out, fed back (assumed synchronous to clk)
//   busy          high while the combinations are being driven
//   done          one-cycle pulse when func_out has been updated
//   func_out      learned table, bit i = out observed for {a,b} = i
//   expected_func reference table             (only with BLINDS_CHECK_EN)
//   mismatch      learned != expected at done (only with BLINDS_CHECK_EN)
//
// Build option: define BLINDS_CHECK_EN to add the compare ports and logic.

module blinds_func_learner #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       sample_in,
  output logic       busy,
  output logic       done,
  output logic [3:0] func_out
`ifdef BLINDS_CHECK_EN
  ,
  input  logic [3:0] expected_func,
  output logic       mismatch
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q,   idx_d;
  logic [7:0] cnt_q,   cnt_d;
  logic [3:0] cap_q,   cap_d;
  logic [3:0] func_q,  func_d;
`ifdef BLINDS_CHECK_EN
  logic       mis_q,   mis_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      func_q  <= '0;
`ifdef BLINDS_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      func_q  <= func_d;
`ifdef BLINDS_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    func_d  = func_q;
`ifdef BLINDS_CHECK_EN
    mis_d   = mis_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
        end
      end

      S_DRIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          cap_d[idx_q] = sample_in;
          cnt_d        = '0;
          if (idx_q != 2'd3) begin
            idx_d = idx_q + 2'd1;
          end else begin
            // idx returns to 0 here so {a,b} reads 00 in DONE and IDLE
            // without a separate output mux.
            state_d = S_DONE;
            idx_d   = '0;
            func_d  = cap_d;
`ifdef BLINDS_CHECK_EN
            mis_d   = (cap_d != expected_func);
`endif
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign a        = idx_q[1];
  assign b        = idx_q[0];
  assign busy     = (state_q == S_DRIVE);
  assign done     = (state_q == S_DONE);
  assign func_out = func_q;
`ifdef BLINDS_CHECK_EN
  assign mismatch = mis_q;
`endif

endmodule

// File: tb/tb_blinds_func_learner.sv
module tb_blinds_func_learner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] func;
  logic [3:0] expected;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          chk_en   = 1'b0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Two instances: SETTLE=1 and SETTLE=3, both fed from the same stimulus.
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int S = (g == 0) ? 1 : 3;

    logic       a, b, busy, done, sample_in;
    logic [3:0] func_out;
`ifdef BLINDS_CHECK_EN
    logic       mismatch;
`endif

    // behavioural blinds unit
    assign sample_in = func[{a, b}];

    blinds_func_learner #(.SETTLE(S)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .sample_in (sample_in),
      .busy      (busy),
      .done      (done),
      .func_out  (func_out)
`ifdef BLINDS_CHECK_EN
      ,
      .expected_func (expected),
      .mismatch      (mismatch)
`endif
    );

    // Reference: pos = cycles elapsed since the accepting edge (-1 = idle).
    // Positions 0..4S-1 drive index pos/S; position 4S is the done cycle.
    int         pos;
    logic [3:0] m_cap, m_func;
    logic       m_mis;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pos    <= -1;
        m_cap  <= '0;
        m_func <= '0;
        m_mis  <= 1'b0;
      end else if (pos < 0) begin
        if (start) begin
          pos   <= 0;
          m_cap <= '0;
        end
      end else if (pos == 4 * S) begin
        pos <= -1;
      end else begin
        if ((pos % S) == S - 1) m_cap[pos / S] <= func[pos / S];
        pos <= pos + 1;
        if (pos == 4 * S - 1) begin
          m_func <= {func[3], m_cap[2:0]};
          m_mis  <= ({func[3], m_cap[2:0]} != expected);
        end
      end
    end

    int         idx_e;
    logic [1:0] idx_b;
    always @(negedge clk) begin
      if (chk_en) begin
        idx_e = (pos >= 0 && pos < 4 * S) ? pos / S : 0;
        idx_b = idx_e[1:0];
        check($sformatf("S%0d_a", S), a, idx_b[1]);
        check($sformatf("S%0d_b", S), b, idx_b[0]);
        check($sformatf("S%0d_busy", S), busy, (pos >= 0 && pos < 4 * S));
        check($sformatf("S%0d_done", S), done, (pos == 4 * S));
        check($sformatf("S%0d_func_out", S), func_out, m_func);
`ifdef BLINDS_CHECK_EN
        check($sformatf("S%0d_mismatch", S), mismatch, m_mis);
`endif
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Assert reset shortly after a rising edge, observe at the falling edge
  // (no rising edge in between), release before the next rising edge.
  task automatic mid_cycle_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    func     = 4'h0;
    expected = 4'h0;
    @(negedge clk);
    chk_en = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // single runs with two different tables
    func = 4'hA;
    pulse_start();
    cycles(16);
    func = 4'h6;
    pulse_start();
    cycles(16);

    // start pulsed mid-run is ignored; then a new table
    func = 4'hA;
    pulse_start();
    cycles(1);
    pulse_start();
    cycles(14);
    func = 4'h5;
    pulse_start();
    cycles(16);

    // reset during the second combination of the SETTLE=3 instance
    func = 4'hF;
    pulse_start();
    cycles(3);
    mid_cycle_reset();
    cycles(12);

    // start held high: back-to-back runs
    func = 4'h9;
    @(negedge clk);
    start = 1'b1;
    cycles(12);
    start = 1'b0;
    cycles(16);

    // compare feature: equal table, then differing table
    expected = 4'hA;
    func     = 4'hA;
    pulse_start();
    cycles(16);
    func = 4'hB;
    pulse_start();
    cycles(16);

    // randomized traffic
    repeat (500) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) func = 4'($urandom);
      if ($urandom_range(0, 5) == 0) expected = $urandom_range(0, 1) ? func : 4'($urandom);
    end
    start = 1'b0;
    mid_cycle_reset();
    cycles(16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
